// File: rtl/psr_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : psr_window_ctrl
//  Purpose  : Processor-state and register-window controller. Holds the
//             integer condition codes (icc), supervisor / previous-supervisor
//             / enable-traps bits, the current window pointer (CWP) and the
//             window invalid mask (WIM). Applies one window/trap command per
//             clock edge and evaluates branch conditions against icc.
//  Ports    : CLK, RESET (async, active high)
//             Flags/SCC          - ALU flags {N,Z,V,C}, latch into icc
//             SAVE/RESTORE       - window decrement / increment (WIM checked)
//             TRAP/RETT          - trap entry / trap return
//             WR_PSR/WR_WIM      - write PSR fields or WIM from PSR_In
//             Cond               - Bicc condition for Branch_Taken
//             Out, CWP, PSR_Out  - registered state views
//             Trap_*             - one-cycle registered trap pulses
//             Error_Mode         - sticky error state
//  Revision : 1.0  initial release
// ============================================================================
module psr_window_ctrl #(
  parameter int NWINDOWS      = 8,
  parameter int DATAWIDTH_BUS = 32,
  localparam int CWP_W        = (NWINDOWS > 2) ? $clog2(NWINDOWS) : 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [3:0]               Flags,
  input  logic                     SCC,
  input  logic                     SAVE,
  input  logic                     RESTORE,
  input  logic                     TRAP,
  input  logic                     RETT,
  input  logic                     WR_PSR,
  input  logic                     WR_WIM,
  input  logic [DATAWIDTH_BUS-1:0] PSR_In,
  input  logic [3:0]               Cond,
  output logic [3:0]               Out,
  output logic [CWP_W-1:0]         CWP,
  output logic [DATAWIDTH_BUS-1:0] PSR_Out,
  output logic                     Branch_Taken,
  output logic                     Trap_Overflow,
  output logic                     Trap_Underflow,
  output logic                     Trap_Illegal,
  output logic                     Error_Mode
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_ERROR = 1'b1
  } state_t;

  localparam logic [CWP_W-1:0] C_CWP_MAX = CWP_W'(NWINDOWS - 1);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_icc, w_icc_nxt;
  logic [CWP_W-1:0]      r_cwp, w_cwp_nxt;
  logic                  r_s, w_s_nxt;
  logic                  r_ps, w_ps_nxt;
  logic                  r_et, w_et_nxt;
  logic [NWINDOWS-1:0]   r_wim, w_wim_nxt;
  logic                  r_tov, w_tov_nxt;
  logic                  r_tun, w_tun_nxt;
  logic                  r_till, w_till_nxt;

  logic [CWP_W-1:0]      w_cwp_dec;
  logic [CWP_W-1:0]      w_cwp_inc;
  logic                  w_psr_cwp_ok;
  logic                  w_cond_base;
  logic [DATAWIDTH_BUS-1:0] w_psr;
  logic                  w_unused_psr_bits;

  // Explicit wrap so non-power-of-two window counts stay in 0..NWINDOWS-1.
  assign w_cwp_dec = (r_cwp == '0)        ? C_CWP_MAX : r_cwp - 1'b1;
  assign w_cwp_inc = (r_cwp == C_CWP_MAX) ? '0        : r_cwp + 1'b1;

  // Six-bit compare so NWINDOWS=32 does not alias to zero.
  assign w_psr_cwp_ok = ({1'b0, PSR_In[4:0]} < 6'(NWINDOWS));

  assign w_unused_psr_bits = &{1'b0, PSR_In};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_RUN;
      r_icc   <= '0;
      r_cwp   <= '0;
      r_s     <= 1'b1;
      r_ps    <= 1'b0;
      r_et    <= 1'b0;
      r_wim   <= '0;
      r_tov   <= 1'b0;
      r_tun   <= 1'b0;
      r_till  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_icc   <= w_icc_nxt;
      r_cwp   <= w_cwp_nxt;
      r_s     <= w_s_nxt;
      r_ps    <= w_ps_nxt;
      r_et    <= w_et_nxt;
      r_wim   <= w_wim_nxt;
      r_tov   <= w_tov_nxt;
      r_tun   <= w_tun_nxt;
      r_till  <= w_till_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_icc_nxt   = r_icc;
    w_cwp_nxt   = r_cwp;
    w_s_nxt     = r_s;
    w_ps_nxt    = r_ps;
    w_et_nxt    = r_et;
    w_wim_nxt   = r_wim;
    w_tov_nxt   = 1'b0;
    w_tun_nxt   = 1'b0;
    w_till_nxt  = 1'b0;

    if (r_state == ST_RUN) begin
      // SCC acts alongside any window command; a legal WR_PSR overrides it.
      if (SCC) begin
        w_icc_nxt = Flags;
      end

      if (WR_PSR) begin
        if (w_psr_cwp_ok) begin
          w_icc_nxt = PSR_In[23:20];
          w_s_nxt   = PSR_In[7];
          w_ps_nxt  = PSR_In[6];
          w_et_nxt  = PSR_In[5];
          w_cwp_nxt = PSR_In[CWP_W-1:0];
        end else begin
          w_till_nxt = 1'b1;
        end
      end else if (WR_WIM) begin
        w_wim_nxt = PSR_In[NWINDOWS-1:0];
      end else if (TRAP) begin
        if (r_et) begin
          w_cwp_nxt = w_cwp_dec;
          w_ps_nxt  = r_s;
          w_s_nxt   = 1'b1;
          w_et_nxt  = 1'b0;
        end else begin
          // Trap with traps disabled: freeze everything, including icc.
          w_state_nxt = ST_ERROR;
          w_icc_nxt   = r_icc;
        end
      end else if (RETT) begin
        if (!r_et && r_s) begin
          w_cwp_nxt = w_cwp_inc;
          w_s_nxt   = r_ps;
          w_et_nxt  = 1'b1;
        end else begin
          w_till_nxt = 1'b1;
        end
      end else if (SAVE) begin
        if (r_wim[w_cwp_dec]) begin
          w_tov_nxt = 1'b1;
        end else begin
          w_cwp_nxt = w_cwp_dec;
        end
      end else if (RESTORE) begin
        if (r_wim[w_cwp_inc]) begin
          w_tun_nxt = 1'b1;
        end else begin
          w_cwp_nxt = w_cwp_inc;
        end
      end
    end
  end

  // Cond[3] inverts conditions 0..7, giving 8 = always and 9..15 = negations.
  always_comb begin
    w_cond_base = 1'b0;
    unique case (Cond[2:0])
      3'd0: w_cond_base = 1'b0;
      3'd1: w_cond_base = r_icc[2];
      3'd2: w_cond_base = r_icc[2] | (r_icc[3] ^ r_icc[1]);
      3'd3: w_cond_base = r_icc[3] ^ r_icc[1];
      3'd4: w_cond_base = r_icc[0] | r_icc[2];
      3'd5: w_cond_base = r_icc[0];
      3'd6: w_cond_base = r_icc[3];
      3'd7: w_cond_base = r_icc[1];
      default: w_cond_base = 1'b0;
    endcase
  end

  always_comb begin
    w_psr              = '0;
    w_psr[23:20]       = r_icc;
    w_psr[7]           = r_s;
    w_psr[6]           = r_ps;
    w_psr[5]           = r_et;
    w_psr[CWP_W-1:0]   = r_cwp;
  end

  assign Out            = r_icc;
  assign CWP            = r_cwp;
  assign PSR_Out        = w_psr;
  assign Branch_Taken   = w_cond_base ^ Cond[3];
  assign Trap_Overflow  = r_tov;
  assign Trap_Underflow = r_tun;
  assign Trap_Illegal   = r_till;
  assign Error_Mode     = (r_state == ST_ERROR);

endmodule
`default_nettype wire
